// File: rtl/dbg_abstract_cmd_ctrl.sv
// Access Register abstract command sequencer: validates a command and runs one RF/CSR transfer to or from data0.
// Optional build macro DBG_ABS_POSTINC_EN enables aarpostincrement (regno+1 written back to the command register).
//
// state | meaning
// IDLE  | waiting for a command write
// CHECK | validate latched command, pick target bus
// XFER  | bus request outstanding, timeout counter running
// DONE  | success; postincrement write-back
// ERR   | pulse cmderr code
module dbg_abstract_cmd_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter int unsigned GPR_COUNT      = 32
) (
    input  logic        iClk,
    input  logic        iRst,
    input  logic        iCmdValid,
    input  logic [31:0] iCmd,
    input  logic        iCmdErrNz,
    input  logic        iHalted,
    input  logic [31:0] iData0,
    output logic        oData0We,
    output logic [31:0] oData0,
    output logic        oCmdWe,
    output logic [31:0] oCmd,
    output logic        oBusy,
    output logic        oErrSet,
    output logic [2:0]  oErrCode,
    output logic        oRfReq,
    output logic        oRfWe,
    output logic [4:0]  oRfAddr,
    output logic [31:0] oRfWData,
    input  logic        iRfAck,
    input  logic [31:0] iRfRData,
    output logic        oCsrReq,
    output logic        oCsrWe,
    output logic [11:0] oCsrAddr,
    output logic [31:0] oCsrWData,
    input  logic        iCsrAck,
    input  logic        iCsrErr,
    input  logic [31:0] iCsrRData
);

`ifdef DBG_ABS_POSTINC_EN
    localparam bit POSTINC_EN = 1'b1;
`else
    localparam bit POSTINC_EN = 1'b0;
`endif

    localparam int          CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [16:0] GPR_BASE = 17'h01000;
    localparam logic [16:0] GPR_END  = 17'(32'h1000 + GPR_COUNT);

    localparam logic [2:0] ERR_BUSY       = 3'd1;
    localparam logic [2:0] ERR_NOT_SUPP   = 3'd2;
    localparam logic [2:0] ERR_EXCEPTION  = 3'd3;
    localparam logic [2:0] ERR_HALT_RESUM = 3'd4;
    localparam logic [2:0] ERR_BUS        = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_XFER,
        S_DONE,
        S_ERR
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       cmd_q, cmd_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        err_code_q, err_code_d;
    logic              req_rf_q, req_rf_d;
    logic              req_csr_q, req_csr_d;
    logic              we_q, we_d;
    logic [11:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              data0_we_q, data0_we_d;
    logic [31:0]       data0_q, data0_d;
    logic              cmd_we_q, cmd_we_d;
    logic [31:0]       cmd_wr_q, cmd_wr_d;

    logic [7:0]  cmd_type;
    logic [2:0]  cmd_size;
    logic        cmd_postinc, cmd_postexec, cmd_transfer, cmd_write;
    logic [15:0] cmd_regno;
    logic        is_csr, is_gpr;
    logic        postinc_fire;
    logic [31:0] cmd_next;
    logic        xfer_ack;
    logic        collide;

    assign cmd_type     = cmd_q[31:24];
    assign cmd_size     = cmd_q[22:20];
    assign cmd_postinc  = cmd_q[19];
    assign cmd_postexec = cmd_q[18];
    assign cmd_transfer = cmd_q[17];
    assign cmd_write    = cmd_q[16];
    assign cmd_regno    = cmd_q[15:0];

    assign is_csr       = cmd_regno <= 16'h0FFF;
    assign is_gpr       = ({1'b0, cmd_regno} >= GPR_BASE) && ({1'b0, cmd_regno} < GPR_END);
    assign postinc_fire = POSTINC_EN && cmd_postinc;
    assign cmd_next     = {cmd_q[31:16], cmd_regno + 16'd1};
    assign xfer_ack     = req_csr_q ? iCsrAck : iRfAck;

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q    <= S_IDLE;
            cmd_q      <= '0;
            cnt_q      <= '0;
            err_code_q <= '0;
            req_rf_q   <= 1'b0;
            req_csr_q  <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            data0_we_q <= 1'b0;
            data0_q    <= '0;
            cmd_we_q   <= 1'b0;
            cmd_wr_q   <= '0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            cnt_q      <= cnt_d;
            err_code_q <= err_code_d;
            req_rf_q   <= req_rf_d;
            req_csr_q  <= req_csr_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            data0_we_q <= data0_we_d;
            data0_q    <= data0_d;
            cmd_we_q   <= cmd_we_d;
            cmd_wr_q   <= cmd_wr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        cnt_d      = cnt_q;
        err_code_d = err_code_q;
        req_rf_d   = req_rf_q;
        req_csr_d  = req_csr_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        data0_we_d = 1'b0;
        data0_d    = '0;
        cmd_we_d   = 1'b0;
        cmd_wr_d   = '0;

        case (state_q)
            S_IDLE: begin
                if (iCmdValid && !iCmdErrNz) begin
                    cmd_d   = iCmd;
                    state_d = S_CHECK;
                end
            end

            S_CHECK: begin
                if ((cmd_type != 8'd0) || (cmd_transfer && (cmd_size != 3'd2)) ||
                    cmd_postexec || (cmd_postinc && !POSTINC_EN)) begin
                    state_d    = S_ERR;
                    err_code_d = ERR_NOT_SUPP;
                end else if (!iHalted) begin
                    state_d    = S_ERR;
                    err_code_d = ERR_HALT_RESUM;
                end else if (!cmd_transfer) begin
                    state_d  = S_DONE;
                    cmd_we_d = postinc_fire;
                    cmd_wr_d = postinc_fire ? cmd_next : '0;
                end else if (is_csr || is_gpr) begin
                    state_d   = S_XFER;
                    req_csr_d = is_csr;
                    req_rf_d  = is_gpr;
                    we_d      = cmd_write;
                    addr_d    = cmd_regno[11:0];
                    wdata_d   = iData0;
                    cnt_d     = '0;
                end else begin
                    state_d    = S_ERR;
                    err_code_d = ERR_EXCEPTION;
                end
            end

            S_XFER: begin
                if (xfer_ack || (cnt_q == CNT_LAST)) begin
                    req_rf_d  = 1'b0;
                    req_csr_d = 1'b0;
                    we_d      = 1'b0;
                    addr_d    = '0;
                    wdata_d   = '0;
                    cnt_d     = '0;
                end
                if (xfer_ack) begin
                    if (req_csr_q && iCsrErr) begin
                        state_d    = S_ERR;
                        err_code_d = ERR_EXCEPTION;
                    end else begin
                        state_d    = S_DONE;
                        data0_we_d = !we_q;
                        data0_d    = we_q ? '0 : (req_csr_q ? iCsrRData : iRfRData);
                        cmd_we_d   = postinc_fire;
                        cmd_wr_d   = postinc_fire ? cmd_next : '0;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d    = S_ERR;
                    err_code_d = ERR_BUS;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // A collision pulse is combinational so the debugger sees cmderr=1 in the write cycle itself.
    assign oBusy    = (state_q != S_IDLE);
    assign collide  = iCmdValid && oBusy;
    assign oErrSet  = (state_q == S_ERR) || collide;
    assign oErrCode = (state_q == S_ERR) ? err_code_q : (collide ? ERR_BUSY : 3'd0);

    assign oData0We  = data0_we_q;
    assign oData0    = data0_q;
    assign oCmdWe    = cmd_we_q;
    assign oCmd      = cmd_wr_q;

    assign oRfReq    = req_rf_q;
    assign oRfWe     = req_rf_q && we_q;
    assign oRfAddr   = req_rf_q ? addr_q[4:0] : 5'd0;
    assign oRfWData  = req_rf_q ? wdata_q : '0;
    assign oCsrReq   = req_csr_q;
    assign oCsrWe    = req_csr_q && we_q;
    assign oCsrAddr  = req_csr_q ? addr_q : 12'd0;
    assign oCsrWData = req_csr_q ? wdata_q : '0;

endmodule
